risc_regfile: RTL and testbench

//   8-entry x 8-bit general-purpose register file for the RISC core datapath.
//   - Two combinational read ports supply ALU operands A and B.
//   - One synchronous write port commits either the ALU result or data-memory

---
 rtl/risc_pkg.sv | 19 +
 rtl/risc_regfile_wrmux.sv | 14 +
 rtl/risc_regfile.sv | 44 ++++
 tb/tb_risc_regfile.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared constants, types and reset pattern
// for the RISC core register file.
package risc_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] data_t;

    // Register i resets to its index in both nibbles (r3 = 8'h33).
    function automatic data_t rst_val(input int i);
        logic [3:0] n;
        n = i[3:0];
        return {n, n};
    endfunction

endpackage

// File: rtl/risc_regfile_wrmux.sv
// Write-data selector: load data or ALU result.
// Ports: load_op (1 = dmdataout), rslt, dmdataout -> wr_data.
module risc_regfile_wrmux
    import risc_pkg::*;
(
    input  logic  load_op,
    input  data_t rslt,
    input  data_t dmdataout,
    output data_t wr_data
);

    assign wr_data = load_op ? dmdataout : rslt;

endmodule

// File: rtl/risc_regfile.sv
// 8 x 8-bit register file: two combinational read ports, one write port.
// Ports: clk, rst_n, reg_wr_vld, load_op, rslt, dmdataout, dst,
//        opnda_addr, opndb_addr -> oprnd_a, oprnd_b.
module risc_regfile
    import risc_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      reg_wr_vld,
    input  logic      load_op,
    input  data_t     rslt,
    input  data_t     dmdataout,
    input  reg_addr_t dst,
    input  reg_addr_t opnda_addr,
    input  reg_addr_t opndb_addr,
    output data_t     oprnd_a,
    output data_t     oprnd_b
);

    data_t regs [NREGS];
    data_t wr_data;

    risc_regfile_wrmux u_wrmux (
        .load_op   (load_op),
        .rslt      (rslt),
        .dmdataout (dmdataout),
        .wr_data   (wr_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= rst_val(i);
            end
        end else if (reg_wr_vld) begin
            regs[dst] <= wr_data;
        end
    end

    // No bypass: a read of dst sees the old value until the edge.
    assign oprnd_a = regs[opnda_addr];
    assign oprnd_b = regs[opndb_addr];

endmodule

// File: tb/tb_risc_regfile.sv
// Self-checking bench for risc_regfile.
// Scoreboard queue of expected read data from a reference model.
module tb_risc_regfile;

    logic       clk;
    logic       rst_n;
    logic       reg_wr_vld;
    logic       load_op;
    logic [7:0] rslt;
    logic [7:0] dmdataout;
    logic [2:0] dst;
    logic [2:0] opnda_addr;
    logic [2:0] opndb_addr;
    logic [7:0] oprnd_a;
    logic [7:0] oprnd_b;

    logic [7:0] model [8];
    logic [7:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    risc_regfile dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_wr_vld (reg_wr_vld),
        .load_op    (load_op),
        .rslt       (rslt),
        .dmdataout  (dmdataout),
        .dst        (dst),
        .opnda_addr (opnda_addr),
        .opndb_addr (opndb_addr),
        .oprnd_a    (oprnd_a),
        .oprnd_b    (oprnd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model[i] = 8'(i * 8'h11);
    endtask

    // Drive both read addresses, queue expectations, then compare.
    task automatic rd(input string tag, input logic [2:0] a,
                      input logic [2:0] b);
        opnda_addr = a;
        opndb_addr = b;
        exp_q.push_back(model[a]);
        exp_q.push_back(model[b]);
        #1;
        chk({tag, "_a"}, oprnd_a, exp_q.pop_front());
        chk({tag, "_b"}, oprnd_b, exp_q.pop_front());
    endtask

    task automatic rd_all(input string tag);
        for (int i = 0; i < 8; i += 2) begin
            rd($sformatf("%s_r%0d", tag, i), 3'(i), 3'(i + 1));
        end
    endtask

    // One write cycle: drive after negedge, commit on posedge.
    task automatic wr(input logic [2:0] d, input logic ld,
                      input logic [7:0] rs, input logic [7:0] dm);
        @(negedge clk);
        reg_wr_vld = 1'b1;
        load_op    = ld;
        dst        = d;
        rslt       = rs;
        dmdataout  = dm;
        @(posedge clk);
        #1;
        model[d]   = ld ? dm : rs;
        reg_wr_vld = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b1;
        reg_wr_vld = 1'b0;
        load_op    = 1'b0;
        rslt       = '0;
        dmdataout  = '0;
        dst        = '0;
        opnda_addr = '0;
        opndb_addr = '0;
        #1 rst_n = 1'b0;
        model_reset();
        #10 rst_n = 1'b1;

        // 1. reset pattern
        rd_all("rst");

        // 2. ALU write
        wr(3'd2, 1'b0, 8'hA5, 8'h3C);
        rd("alu_r2", 3'd2, 3'd2);
        rd_all("alu_all");

        // 3. load writes, every dst
        wr(3'd7, 1'b1, 8'h00, 8'h5A);
        rd("ld_r7", 3'd7, 3'd0);
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), 1'b1, 8'(~i), 8'(8'hC3 ^ (i * 8'h25)));
        end
        rd_all("ld_all");
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), 1'(i % 2), 8'($urandom), 8'($urandom));
        end
        rd_all("mix_all");

        // 4. write disabled
        @(negedge clk);
        model_reset();
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        reg_wr_vld = 1'b0;
        dst        = 3'd4;
        rslt       = 8'hFF;
        dmdataout  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            rd($sformatf("nowr%0d", i), 3'd4, 3'd4);
        end

        // 5. read-during-write, no bypass
        @(negedge clk);
        opnda_addr = 3'd1;
        opndb_addr = 3'd1;
        reg_wr_vld = 1'b1;
        load_op    = 1'b0;
        dst        = 3'd1;
        rslt       = 8'h9C;
        #1;
        chk("rdw_pre_a", oprnd_a, 8'h11);
        chk("rdw_pre_b", oprnd_b, 8'h11);
        @(posedge clk);
        #1;
        reg_wr_vld = 1'b0;
        model[1] = 8'h9C;
        chk("rdw_post_a", oprnd_a, 8'h9C);
        chk("rdw_post_b", oprnd_b, 8'h9C);

        // 6. async reset between edges
        wr(3'd3, 1'b0, 8'hEE, 8'h00);
        rd("arst_pre", 3'd3, 3'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        rd("arst_now", 3'd3, 3'd1);
        #1 rst_n = 1'b1;
        rd_all("arst_all");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
